// File: rtl/joy_serial_scanner.sv
// Serial joystick/button scanner for 74HC165-style parallel-in/serial-out chains.
// Loads the chain, clocks NCHAN*BITS bits out MSB-first, inverts the active-low pins
// and publishes them on buttons with a one-clk valid strobe. Optional two-scan filter.
module joy_serial_scanner #(
  parameter int unsigned NCHAN     = 2,
  parameter int unsigned BITS      = 8,
  parameter int unsigned CLKDIV    = 14,
  parameter int unsigned GAP_TICKS = 16,
  parameter bit          FILTER    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   joy_data,
  output logic                   joy_clk,
  output logic                   joy_load_n,
  output logic [NCHAN*BITS-1:0]  buttons,
  output logic                   valid,
  output logic                   busy
);

  localparam int unsigned NBits = NCHAN * BITS;
  localparam int unsigned PreW  = $clog2(CLKDIV);
  localparam int unsigned GapW  = $clog2(GAP_TICKS + 1);
  localparam int unsigned BitW  = (NBits > 2) ? $clog2(NBits) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StShiftLo, StShiftHi, StLatch} state_e;

  state_e             state_q, state_d;
  logic [PreW-1:0]    pre_q;
  logic               tick;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [NBits-1:0]   sh_q, sh_d;
  logic [NBits-1:0]   prev_q, prev_d;
  logic [NBits-1:0]   buttons_q, buttons_d;
  logic [NBits-1:0]   raw, agree;
  logic               valid_q, valid_d;
  logic               jclk_q, jclk_d;
  logic               load_n_q, load_n_d;

  assign tick = (pre_q == PreW'(CLKDIV - 1));

  // Prescaler; it pauses for the LATCH clk so the scan period includes that extra clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (state_q != StLatch) begin
      pre_q <= tick ? '0 : pre_q + PreW'(1);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      gap_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      prev_q    <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      jclk_q    <= 1'b0;
      load_n_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      prev_q    <= prev_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      jclk_q    <= jclk_d;
      load_n_q  <= load_n_d;
    end
  end

  // Next-state logic: every step except LATCH waits for a tick.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          // The GAP_TICKS-th tick starts the scan; with enable low the counter saturates
          // so the scan begins on the first enabled tick.
          if (gap_q >= GapW'(GAP_TICKS - 1) && enable) begin
            gap_d   = '0;
            bit_d   = '0;
            state_d = StLoad;
          end else if (gap_q != GapW'(GAP_TICKS)) begin
            gap_d = gap_q + GapW'(1);
          end
        end
      end
      StLoad: begin
        if (tick) begin
          if (bit_q == BitW'(1)) begin
            bit_d   = '0;
            state_d = StShiftLo;
          end else begin
            bit_d = BitW'(1);
          end
        end
      end
      StShiftLo: begin
        if (tick) begin
          sh_d    = (sh_q << 1) | NBits'(joy_data);
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (tick) begin
          if (bit_q == BitW'(NBits - 1)) begin
            state_d = StLatch;
          end else begin
            bit_d   = bit_q + BitW'(1);
            state_d = StShiftLo;
          end
        end
      end
      StLatch: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: pin strobes follow the next state so they come straight from flops.
  always_comb begin
    raw       = ~sh_q;
    agree     = ~(raw ^ prev_q);
    jclk_d    = (state_d == StShiftHi);
    load_n_d  = (state_d != StLoad);
    valid_d   = (state_q == StLatch);
    buttons_d = buttons_q;
    prev_d    = prev_q;
    if (state_q == StLatch) begin
      prev_d = raw;
      if (FILTER) begin
        buttons_d = (raw & agree) | (buttons_q & ~agree);
      end else begin
        buttons_d = raw;
      end
    end
  end

  assign joy_clk    = jclk_q;
  assign joy_load_n = load_n_q;
  assign buttons    = buttons_q;
  assign valid      = valid_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_joy_serial_scanner.sv
// Bench for joy_serial_scanner: three instances (small unfiltered, small filtered, default
// parameters), each driven by a behavioural 74HC165 chain model.
module tb_joy_serial_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Instance 0: NCHAN=2 BITS=4 CLKDIV=2 GAP=4 FILTER=0
  logic rst0 = 1'b1, en0 = 1'b0, data0, jclk0, load0, valid0, busy0, jclk0_d;
  logic [7:0] btn0, pins0 = 8'hFF, sh0;
  // Instance 1: same, FILTER=1
  logic rst1 = 1'b1, en1 = 1'b0, data1, jclk1, load1, valid1, busy1, jclk1_d;
  logic [7:0] btn1, pins1 = 8'hFF, sh1;
  // Instance 2: default parameters
  logic rst2 = 1'b1, en2 = 1'b0, data2, jclk2, load2, valid2, busy2, jclk2_d;
  logic [15:0] btn2, pins2 = 16'hFFFF, sh2;

  joy_serial_scanner #(.NCHAN(2), .BITS(4), .CLKDIV(2), .GAP_TICKS(4), .FILTER(1'b0)) u_f0 (
    .clk(clk), .rst(rst0), .enable(en0), .joy_data(data0), .joy_clk(jclk0),
    .joy_load_n(load0), .buttons(btn0), .valid(valid0), .busy(busy0)
  );
  joy_serial_scanner #(.NCHAN(2), .BITS(4), .CLKDIV(2), .GAP_TICKS(4), .FILTER(1'b1)) u_f1 (
    .clk(clk), .rst(rst1), .enable(en1), .joy_data(data1), .joy_clk(jclk1),
    .joy_load_n(load1), .buttons(btn1), .valid(valid1), .busy(busy1)
  );
  joy_serial_scanner u_def (
    .clk(clk), .rst(rst2), .enable(en2), .joy_data(data2), .joy_clk(jclk2),
    .joy_load_n(load2), .buttons(btn2), .valid(valid2), .busy(busy2)
  );

  // Chain models: parallel load while load_n is low, shift toward Q7 on each joy_clk rise.
  always @(posedge clk) begin
    jclk0_d <= jclk0;
    if (!load0) sh0 <= pins0;
    else if (jclk0 && !jclk0_d) sh0 <= {sh0[6:0], 1'b1};
  end
  always @(posedge clk) begin
    jclk1_d <= jclk1;
    if (!load1) sh1 <= pins1;
    else if (jclk1 && !jclk1_d) sh1 <= {sh1[6:0], 1'b1};
  end
  always @(posedge clk) begin
    jclk2_d <= jclk2;
    if (!load2) sh2 <= pins2;
    else if (jclk2 && !jclk2_d) sh2 <= {sh2[14:0], 1'b1};
  end
  assign data0 = sh0[7];
  assign data1 = sh1[7];
  assign data2 = sh2[15];

  function automatic logic load_of(input int s);
    case (s)
      0:       return load0;
      1:       return load1;
      default: return load2;
    endcase
  endfunction

  function automatic logic valid_of(input int s);
    case (s)
      0:       return valid0;
      1:       return valid1;
      default: return valid2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_load_low(input int s, input int budget, output int n);
    n = 0;
    while (load_of(s) !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_load_high(input int s, input int budget);
    int n = 0;
    while (load_of(s) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_valid(input int s, input int budget);
    int n = 0;
    @(negedge clk);
    while (valid_of(s) !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Filter reference: a button takes the new raw value only where two scans agree.
  logic [7:0] m_btn = 8'h00, m_prev = 8'h00;
  task automatic filter_model(input logic [7:0] r);
    for (int i = 0; i < 8; i++) begin
      if (r[i] == m_prev[i]) m_btn[i] = r[i];
    end
    m_prev = r;
  endtask

  logic [7:0] f_raw [5] = '{8'h01, 8'h03, 8'h03, 8'hFF, 8'h03};
  logic [7:0] f_exp [5] = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h03};

  initial begin
    int n, w, pulses, run, bad, lows, vals;
    longint t1, t2;
    logic [7:0] r;

    // ---------------- Basic scan on instance 0 ----------------
    en0   = 1'b1;
    pins0 = 8'b0111_1110;
    repeat (3) @(negedge clk);
    check("reset_idle_load_n", load0, 1'b1);
    check("reset_idle_busy", busy0, 1'b0);
    rst0 = 1'b0;

    wait_load_low(0, 100, n);
    t1 = $time;
    check("first_load_seen", load0, 1'b0);
    w = 0;
    while (load0 === 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("load_low_clks", w, 4);

    pulses = 0; run = 0; bad = 0; n = 0;
    while (valid0 !== 1'b1 && n < 200) begin
      if (jclk0 === 1'b1) run++;
      else if (run != 0) begin
        if (run != 2) bad++;
        pulses++;
        run = 0;
      end
      @(negedge clk);
      n++;
    end
    check("valid_after_scan", valid0, 1'b1);
    check("jclk_pulse_count", pulses, 8);
    check("jclk_pulse_width_errs", bad, 0);
    check("basic_buttons", btn0, 8'h81);
    @(negedge clk);
    check("valid_one_clk", valid0, 1'b0);
    wait_load_low(0, 100, n);
    t2 = $time;
    check("valid_to_next_load", n + 1, 8);
    check("scan_period_clks", (t2 - t1) / 10, 45);
    wait_valid(0, 200);
    check("repeat_buttons", btn0, 8'h81);

    // Random patterns against the inverted-pin reference
    for (int k = 0; k < 6; k++) begin
      pins0 = 8'($urandom);
      wait_valid(0, 200);
      check("rand_buttons_f0", btn0, {56'h0, ~pins0});
    end

    // Channel mapping
    pins0 = {4'b1110, 4'b0111};
    wait_valid(0, 200);
    check("chan1_nibble", btn0[7:4], 4'h1);
    check("chan0_nibble", btn0[3:0], 4'h8);

    // ---------------- Reset mid-SHIFT ----------------
    n = 0;
    while (jclk0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("reached_shift", jclk0, 1'b1);
    rst0 = 1'b1;
    @(negedge clk);
    check("rst_joy_clk", jclk0, 1'b0);
    check("rst_load_n", load0, 1'b1);
    check("rst_buttons", btn0, 8'h00);
    check("rst_valid", valid0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    repeat (2) @(negedge clk);
    en0  = 1'b0;
    rst0 = 1'b0;

    // ---------------- Enable gating ----------------
    lows = 0; vals = 0;
    repeat (200) begin
      @(negedge clk);
      if (load0 === 1'b0) lows++;
      if (valid0 === 1'b1) vals++;
    end
    check("disabled_no_load", lows, 0);
    check("disabled_no_valid", vals, 0);
    check("disabled_btn_clear", btn0, 8'h00);

    pins0 = 8'($urandom);
    en0 = 1'b1;
    wait_load_low(0, 50, n);
    check("enable_to_load_within_tick", (n >= 1 && n <= 2), 1'b1);
    n = 0;
    while (jclk0 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    en0 = 1'b0;
    wait_valid(0, 200);
    check("drop_enable_scan_completes", valid0, 1'b1);
    check("drop_enable_buttons", btn0, {56'h0, ~pins0});
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (load0 === 1'b0) lows++;
    end
    check("no_load_after_disable", lows, 0);

    // ---------------- Filter on instance 1 ----------------
    en1 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pins1 = ~f_raw[k];
      if (k == 0) rst1 = 1'b0;
      wait_valid(1, 200);
      filter_model(f_raw[k]);
      check("filter_directed", btn1, {56'h0, f_exp[k]});
    end
    r = f_raw[4];
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) r = 8'($urandom);
      pins1 = ~r;
      wait_valid(1, 200);
      filter_model(r);
      check("filter_random", btn1, {56'h0, m_btn});
    end

    // ---------------- Default parameters on instance 2 ----------------
    pins2 = 16'($urandom);
    en2   = 1'b1;
    rst2  = 1'b0;
    wait_load_low(2, 2000, n);
    t1 = $time;
    check("def_first_load", load2, 1'b0);
    wait_load_high(2, 2000);
    wait_valid(2, 2000);
    check("def_valid", valid2, 1'b1);
    check("def_buttons", btn2, {48'h0, ~pins2});
    wait_load_low(2, 2000, n);
    t2 = $time;
    check("def_period_clks", (t2 - t1) / 10, 701);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/joy_serial_scanner.md
Name: joy_serial_scanner

Overview:
- Parametrised serial joystick/button scanner for external parallel-in/serial-out shift-register chains (74HC165 style) on the board joystick port.
- Generalises the fixed two-joystick decoder:
  - any number of channels and bits per channel;
  - programmable bit-clock rate and inter-scan gap;
  - optional two-scan agreement filter;
  - scan-enable input and a per-scan valid strobe.
- Sits between the board pins (joy_data/joy_clk/joy_load_n) and the core's joystick inputs, in the system clock domain.

Parameters:
- NCHAN, 2, number of controllers in the chain.
- BITS, 8, bits per controller (inputs are active-low at the pin).
- CLKDIV, 14, system clocks per tick (tick = half period of joy_clk); must be >= 2.
- GAP_TICKS, 16, idle ticks between scans; must be >= 1.
- FILTER, 0, 1 = a button output changes only when two consecutive scans agree.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  1 = scanning allowed; sampled only in IDLE.
- joy_data  in  1  serial data from the chain, active-low button state.
- joy_clk  out  1  shift clock to the chain.
- joy_load_n  out  1  parallel-load strobe to the chain, active-low.
- buttons  out  NCHAN*BITS  decoded state, 1 = pressed; channel c = buttons[c*BITS +: BITS].
- valid  out  1  one-clk pulse when buttons has been (re)written.
- busy  out  1  1 while the FSM is not in IDLE.

Behaviour:
- Reset values: joy_clk=0, joy_load_n=1, buttons=0, valid=0, busy=0, state IDLE, prescaler=0, gap counter=0, previous-raw register all 0.
- Reset mid-scan aborts immediately to the reset values; no partial data is ever latched.
- Prescaler:
  - counts 0..CLKDIV-1 continuously;
  - tick = 1 on the clk where count==CLKDIV-1;
  - all state steps except LATCH happen on tick.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - gap counter increments per tick;
  - when it reaches GAP_TICKS and enable=1 on that tick: clear the counter, enter LOAD;
  - if enable=0, hold the counter at GAP_TICKS and stay, so the scan starts on the first tick with enable=1.
- LOAD: joy_load_n=0 for exactly 2 ticks, joy_clk=0, then SHIFT_LO with bit counter=0.
- SHIFT_LO, on tick:
  - shift joy_data into LSB of an NCHAN*BITS shift register (shift left);
  - drive joy_clk=1;
  - go SHIFT_HI.
- SHIFT_HI, on tick:
  - drive joy_clk=0;
  - if bit counter == NCHAN*BITS-1, go LATCH; else increment the counter and go SHIFT_LO.
- Bit order: the first bit sampled ends at buttons[NCHAN*BITS-1]; the last sampled ends at buttons[0].
- LATCH (a single clk, no tick wait):
  - raw = ~shiftreg;
  - FILTER=0: buttons <= raw.
  - FILTER=1: buttons[i] <= raw[i] where raw[i]==prev[i], else it holds.
  - prev <= raw in both modes.
  - valid=1 for this clk only; next state IDLE.
- busy = (state != IDLE).
- Scan length = 2 + 2*NCHAN*BITS ticks; period with enable held high = (GAP_TICKS + 2 + 2*NCHAN*BITS)*CLKDIV clks, plus 1 clk for LATCH.
- enable falling mid-scan has no effect; the current scan completes and latches.
- joy_clk and joy_load_n are registered outputs, glitch-free.
- joy_data is used directly at sample time; the board path is slow relative to the tick, so no synchroniser is required.

Test Plan:
- Bench parameters for all scenarios unless stated: NCHAN=2, BITS=4, CLKDIV=2, GAP_TICKS=4.
- Reset: hold rst 3 clks mid-SHIFT -> joy_clk=0, joy_load_n=1, buttons=8'h00, valid=0, busy=0 on the clk after rst.
- Basic scan, FILTER=0:
  - stimulus: chain model presents serial pattern 8'b0111_1110 MSB-first;
  - required: joy_load_n low exactly 4 clks;
  - required: 8 joy_clk high pulses of 2 clks each;
  - required: buttons=8'h81 with a 1-clk valid;
  - required: next load_n fall is 8 clks + LATCH clk later.
- Channel mapping: chain loaded with channel 1 = 4'b1110, channel 0 = 4'b0111 (active-low) -> buttons[7:4]=4'h1, buttons[3:0]=4'h8.
- Filter, FILTER=1:
  - scans present raw 8'h01, 8'h03, 8'h03;
  - required buttons after each valid: 8'h00, 8'h01, 8'h03;
  - a 1-scan glitch to 8'hFF between two 8'h03 scans leaves buttons=8'h03.
- Enable gating:
  - enable=0 from reset -> joy_load_n stays 1 and valid never pulses over 200 clks.
  - raising enable -> LOAD starts on the next tick.
  - dropping enable during SHIFT -> that scan still completes with valid=1, then no further LOAD.
- Default parameters: NCHAN=2, BITS=8, CLKDIV=14, GAP_TICKS=16 -> measured load_n falling-edge spacing = 50*14+1 = 701 clks.
